// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard sources in, PC and pipeline-register controls out.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic [1:0]        ex_jump;
    logic              mem_req;
    logic              mem_ready;
    logic              pc_stall;
    logic              pc_from_taken;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_mem_stall;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_branch_taken, ex_jump, mem_req, mem_ready,
        input  pc_stall, pc_from_taken, if_id_stall, if_id_flush, id_ex_flush,
               ex_mem_stall, mem_timeout, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_branch_taken, ex_jump, mem_req, mem_ready,
        output pc_stall, pc_from_taken, if_id_stall, if_id_flush, id_ex_flush,
               ex_mem_stall, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: mem-wait freeze, branch redirect flush, load-use bubble.
module hazard_ctrl #(
    parameter int unsigned REG_AW          = 5,
    parameter int unsigned REDIRECT_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter int unsigned CNT_W           = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned RC_W = 3;
    localparam int unsigned WT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [RC_W-1:0]  RC_INIT = RC_W'(REDIRECT_CYCLES - 1);
    localparam logic [WT_W-1:0]  WT_MAX  = WT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT, LOAD_BUBBLE} state_t;

    state_t           state_q, state_nxt;
    logic [RC_W-1:0]  rcnt_q, rcnt_nxt;
    logic [WT_W-1:0]  wait_q, wait_inc;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic mw_c, taken_c, lu_c;
    logic pc_stall_c, pc_from_taken_c, if_id_stall_c, if_id_flush_c, id_ex_flush_c, ex_mem_stall_c;

    // Hazard classification from the current ID/EX/MEM contents
    assign mw_c    = hz.mem_req & ~hz.mem_ready;
    assign taken_c = hz.ex_branch_taken | (hz.ex_jump != 2'b00);
    assign lu_c    = hz.ex_mem_read & (hz.ex_rd != REG_AW'(0)) &
                     ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd)) |
                      (hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_nxt;
            rcnt_q  <= rcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        rcnt_nxt  = rcnt_q;
        case (state_q)
            RUN: begin
                if (mw_c) begin
                    state_nxt = MEM_WAIT;
                end else if (taken_c) begin
                    if (REDIRECT_CYCLES > 1) begin
                        state_nxt = REDIRECT;
                        rcnt_nxt  = RC_INIT;
                    end
                end else if (lu_c) begin
                    state_nxt = LOAD_BUBBLE;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) state_nxt = RUN;
            end
            REDIRECT: begin
                // A freeze holds the remaining flush count
                if (!mw_c) begin
                    rcnt_nxt = rcnt_q - RC_W'(1);
                    if (rcnt_q == RC_W'(1)) state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = mw_c ? MEM_WAIT : RUN;
            end
        endcase
    end

    always_comb begin
        pc_stall_c      = 1'b0;
        pc_from_taken_c = 1'b0;
        if_id_stall_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_flush_c   = 1'b0;
        ex_mem_stall_c  = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (mw_c) begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        ex_mem_stall_c = 1'b1;
                    end else if (taken_c) begin
                        pc_from_taken_c = 1'b1;
                        if_id_flush_c   = 1'b1;
                        id_ex_flush_c   = 1'b1;
                    end else if (lu_c) begin
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    pc_stall_c     = ~hz.mem_ready;
                    if_id_stall_c  = ~hz.mem_ready;
                    ex_mem_stall_c = ~hz.mem_ready;
                end
                REDIRECT: begin
                    pc_stall_c     = mw_c;
                    if_id_stall_c  = mw_c;
                    ex_mem_stall_c = mw_c;
                    if_id_flush_c  = ~mw_c;
                    id_ex_flush_c  = ~mw_c;
                end
                default: begin
                    pc_stall_c     = mw_c;
                    if_id_stall_c  = mw_c;
                    ex_mem_stall_c = mw_c;
                end
            endcase
        end
    end

    // Wait counter saturates at the timeout so a long stall cannot wrap it
    assign wait_inc = (wait_q == WT_MAX) ? wait_q : wait_q + WT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (ex_mem_stall_c) begin
                wait_q <= wait_inc;
                if (wait_inc == WT_MAX) timeout_q <= 1'b1;
            end else begin
                wait_q <= '0;
            end
            if (pc_stall_c && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign hz.pc_stall      = pc_stall_c;
    assign hz.pc_from_taken = pc_from_taken_c;
    assign hz.if_id_stall   = if_id_stall_c;
    assign hz.if_id_flush   = if_id_flush_c;
    assign hz.id_ex_flush   = id_ex_flush_c;
    assign hz.ex_mem_stall  = ex_mem_stall_c;
    assign hz.mem_timeout   = timeout_q;
    assign hz.stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (REDIRECT_CYCLES 1/3/4) against a per-cycle model plus directed literals.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic [1:0] ex_jump;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(3))  i0 ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) i1 ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) i2 ();

    assign i0.id_rs1 = id_rs1, i0.id_rs2 = id_rs2, i0.id_rs1_used = id_rs1_used,
           i0.id_rs2_used = id_rs2_used, i0.ex_rd = ex_rd, i0.ex_mem_read = ex_mem_read,
           i0.ex_branch_taken = ex_branch_taken, i0.ex_jump = ex_jump,
           i0.mem_req = mem_req, i0.mem_ready = mem_ready;
    assign i1.id_rs1 = id_rs1, i1.id_rs2 = id_rs2, i1.id_rs1_used = id_rs1_used,
           i1.id_rs2_used = id_rs2_used, i1.ex_rd = ex_rd, i1.ex_mem_read = ex_mem_read,
           i1.ex_branch_taken = ex_branch_taken, i1.ex_jump = ex_jump,
           i1.mem_req = mem_req, i1.mem_ready = mem_ready;
    assign i2.id_rs1 = id_rs1, i2.id_rs2 = id_rs2, i2.id_rs1_used = id_rs1_used,
           i2.id_rs2_used = id_rs2_used, i2.ex_rd = ex_rd, i2.ex_mem_read = ex_mem_read,
           i2.ex_branch_taken = ex_branch_taken, i2.ex_jump = ex_jump,
           i2.mem_req = mem_req, i2.mem_ready = mem_ready;

    hazard_ctrl #(.REG_AW(5), .REDIRECT_CYCLES(1), .MEM_TIMEOUT(8), .CNT_W(3))
        u0 (.clk(clk), .reset(reset), .hz(i0));
    hazard_ctrl #(.REG_AW(5), .REDIRECT_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(16))
        u1 (.clk(clk), .reset(reset), .hz(i1));
    hazard_ctrl #(.REG_AW(5), .REDIRECT_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(16))
        u2 (.clk(clk), .reset(reset), .hz(i2));

    // Flag order: pc_stall, pc_from_taken, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_timeout
    logic [6:0]  fl  [3];
    logic [15:0] cnt [3];
    assign fl[0] = {i0.pc_stall, i0.pc_from_taken, i0.if_id_stall, i0.if_id_flush,
                    i0.id_ex_flush, i0.ex_mem_stall, i0.mem_timeout};
    assign fl[1] = {i1.pc_stall, i1.pc_from_taken, i1.if_id_stall, i1.if_id_flush,
                    i1.id_ex_flush, i1.ex_mem_stall, i1.mem_timeout};
    assign fl[2] = {i2.pc_stall, i2.pc_from_taken, i2.if_id_stall, i2.if_id_flush,
                    i2.id_ex_flush, i2.ex_mem_stall, i2.mem_timeout};
    assign cnt[0] = 16'(i0.stall_cnt);
    assign cnt[1] = i1.stall_cnt;
    assign cnt[2] = i2.stall_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: what the pipeline must see, tracked as pending flushes / waiting / bubble owed
    int rc [3]         = '{1, 3, 4};
    int cmax [3]       = '{7, 65535, 65535};
    int flush_left [3] = '{0, 0, 0};
    int wait_len [3]   = '{0, 0, 0};
    int scnt [3]       = '{0, 0, 0};
    bit waiting [3]    = '{0, 0, 0};
    bit bubble [3]     = '{0, 0, 0};
    bit tmo [3]        = '{0, 0, 0};

    bit fz, ls, pt, fls, mw, tk, lu;
    logic [6:0] e;
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            mw = mem_req && !mem_ready;
            tk = ex_branch_taken || (ex_jump != 2'b00);
            lu = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
            fz = 0; ls = 0; pt = 0; fls = 0;
            if (!reset) begin
                if (waiting[k]) begin
                    fz = !mem_ready;
                    if (mem_ready) waiting[k] = 0;
                end else if (flush_left[k] > 0) begin
                    if (mw) fz = 1;
                    else begin fls = 1; flush_left[k]--; end
                end else if (bubble[k]) begin
                    bubble[k] = 0;
                    if (mw) begin fz = 1; waiting[k] = 1; end
                end else if (mw) begin
                    fz = 1; waiting[k] = 1;
                end else if (tk) begin
                    pt = 1; fls = 1; flush_left[k] = rc[k] - 1;
                end else if (lu) begin
                    ls = 1; bubble[k] = 1;
                end
            end
            e = {fz | ls, pt, fz | ls, fls, fls | ls, fz, tmo[k]};
            chk($sformatf("model_flags%0d", k), 32'(fl[k]), 32'(e));
            chk($sformatf("model_cnt%0d", k), 32'(cnt[k]), 32'(scnt[k]));
            if (reset) begin
                flush_left[k] = 0; wait_len[k] = 0; scnt[k] = 0;
                waiting[k] = 0; bubble[k] = 0; tmo[k] = 0;
            end else begin
                if (fz) begin
                    if (wait_len[k] < 8) wait_len[k]++;
                    if (wait_len[k] == 8) tmo[k] = 1;
                end else begin
                    wait_len[k] = 0;
                end
                if ((fz || ls) && scnt[k] < cmax[k]) scnt[k]++;
            end
        end
    end

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_mem_read = 0; ex_branch_taken = 0; ex_jump = 0; mem_req = 0; mem_ready = 0;
    endtask
    task automatic neg(); @(negedge clk); endtask
    task automatic pos(); @(posedge clk); #1; endtask
    task automatic go(input int n);
        repeat (n) begin neg(); pos(); end
    endtask
    task automatic do_reset();
        reset = 1; idle(); go(1); reset = 0;
    endtask

    initial begin
        reset = 1; idle();
        go(2); reset = 0;
        neg(); chk("rst_flags", 32'(fl[1]), 0); chk("rst_cnt", 32'(cnt[1]), 0); pos();

        // Load-use on rs2, then a bubble cycle even with the hazard still visible
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
        neg(); chk("lu_stall", 32'(fl[0][6:1]), 32'b101010); pos();
        neg(); chk("lu_bubble", 32'(fl[0][6:1]), 0); pos();
        idle();
        neg(); chk("lu_cnt", 32'(cnt[0]), 1); pos();
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_rs2_used = 1;
        neg(); chk("lu_rd0", 32'(fl[0][6]), 0); pos();
        ex_rd = 7; id_rs1 = 7; id_rs1_used = 1;
        neg(); chk("lu_rs1", 32'(fl[0][6:1]), 32'b101010); pos();
        idle(); ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_rs2_used = 0;
        go(1);
        neg(); chk("lu_unused", 32'(fl[0][6]), 0); pos();

        // Taken branch held two cycles: RC=1 redirects twice, RC=3 ignores the second
        do_reset();
        ex_branch_taken = 1;
        neg(); chk("br_c1_r1", 32'(fl[0][6:1]), 32'b010110);
               chk("br_c1_r3", 32'(fl[1][6:1]), 32'b010110); pos();
        neg(); chk("br_c2_r1", 32'(fl[0][6:1]), 32'b010110);
               chk("br_c2_r3", 32'(fl[1][6:1]), 32'b000110); pos();
        idle();
        neg(); chk("br_c3_r1", 32'(fl[0][6:1]), 0);
               chk("br_c3_r3", 32'(fl[1][6:1]), 32'b000110); pos();
        neg(); chk("br_c4_r3", 32'(fl[1][6:1]), 0); pos();
        ex_jump = 2'b10;
        neg(); chk("jalr_r1", 32'(fl[0][6:1]), 32'b010110); pos();
        idle(); go(4);

        // Memory wait of four cycles
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            neg(); chk($sformatf("mw_freeze%0d", i), 32'(fl[1][6:1]), 32'b101001); pos();
        end
        mem_ready = 1;
        neg(); chk("mw_release", 32'(fl[1][6:1]), 0); pos();
        idle();
        neg(); chk("mw_cnt", 32'(cnt[1]), 4); pos();

        // Mem-wait, taken and load-use together; redirect only after the wait
        do_reset();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
        for (int i = 0; i < 2; i++) begin
            neg(); chk($sformatf("sim_freeze%0d", i), 32'(fl[1][6:1]), 32'b101001); pos();
        end
        mem_ready = 1;
        neg(); chk("sim_release", 32'(fl[1][6:1]), 0); pos();
        mem_req = 0; mem_ready = 0;
        neg(); chk("sim_redirect", 32'(fl[1][6:1]), 32'b010110); pos();
        idle(); go(4);

        // Timeout after the eighth wait cycle, sticky through release
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            neg(); chk($sformatf("tmo_low%0d", i), 32'(fl[2][0]), 0); pos();
        end
        neg(); chk("tmo_rise", 32'(fl[2][0]), 1); pos();
        mem_ready = 1;
        neg(); chk("tmo_release", 32'(fl[2][0]), 1); pos();
        idle();
        neg(); chk("tmo_sticky", 32'(fl[2][0]), 1);
               chk("cnt_sat3", 32'(cnt[0]), 7); chk("cnt_9", 32'(cnt[1]), 9); pos();
        do_reset();
        neg(); chk("tmo_cleared", 32'(fl[2][0]), 0); chk("cnt_cleared", 32'(cnt[2]), 0); pos();

        // Reset in the second redirect cycle of RC=4 discards the remaining flushes
        ex_branch_taken = 1;
        neg(); chk("rr_c1", 32'(fl[2][6:1]), 32'b010110); pos();
        idle(); reset = 1;
        neg(); chk("rr_in_reset", 32'(fl[2][6:1]), 0); pos();
        reset = 0;
        neg(); chk("rr_after", 32'(fl[2][6:1]), 0); pos();
        go(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage mini CPU.
- Decides each cycle whether the PC register holds, loads the sequential/predicted PC, or loads the EX-stage redirect target.
- Drives stall and flush for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three hazard classes: data-memory wait, taken branch/jump, and load-use.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_AW, 5, register-file address width
REDIRECT_CYCLES, 1, cycles the IF/ID and ID/EX flush is held after a redirect (1..4)
MEM_TIMEOUT, 255, data-memory wait cycles before mem_timeout is set
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
id_rs1  in  REG_AW  rs1 address of the instruction in ID
id_rs2  in  REG_AW  rs2 address of the instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  rd of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX branch condition true (branch & alu_result[0])
ex_jump  in  2  EX jump type; bit1 = register-indirect (JALR), nonzero = jump
mem_req  in  1  MEM stage has an active data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_stall  out  1  hold the PC register
pc_from_taken  out  1  PC loads the redirect target (branch/jump)
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID to a bubble
id_ex_flush  out  1  clear ID/EX to a bubble
ex_mem_stall  out  1  hold EX/MEM and all earlier stages
mem_timeout  out  1  sticky error flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- All outputs are combinational from state and inputs, except mem_timeout and stall_cnt, which are registered.
- Reset, synchronous: state=RUN, redirect counter=0, wait counter=0, mem_timeout=0, stall_cnt=0.
  - All combinational outputs are 0 while reset=1.
  - Reset mid-operation discards any pending wait or redirect.
- The load-use hazard `lu` is true when all of the following hold:
  - ex_mem_read=1
  - ex_rd != 0
  - (id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)
- `taken` = ex_branch_taken | (ex_jump != 0).
- States: RUN, MEM_WAIT, REDIRECT, LOAD_BUBBLE.
- RUN, fixed priority mem-wait > taken > lu:
  1. mem_req & !mem_ready:
     - pc_stall = if_id_stall = ex_mem_stall = 1
     - no flushes; pc_from_taken = 0
     - next state MEM_WAIT
  2. taken:
     - pc_from_taken = 1; if_id_flush = id_ex_flush = 1; pc_stall = 0
     - If REDIRECT_CYCLES > 1: go to REDIRECT with counter = REDIRECT_CYCLES-1. Otherwise stay in RUN.
  3. lu:
     - pc_stall = if_id_stall = id_ex_flush = 1
     - next state LOAD_BUBBLE
  4. Otherwise all outputs are 0.
- MEM_WAIT:
  - While mem_ready=0: freeze outputs (as in RUN case 1) and increment the wait counter.
  - When the wait counter reaches MEM_TIMEOUT: set mem_timeout (sticky until reset) and keep waiting.
  - When mem_ready=1: freeze deasserts in the same cycle, the wait counter clears, and the next state is RUN.
  - A branch frozen in EX is re-evaluated in RUN afterwards; taken/lu are ignored while in MEM_WAIT.
- REDIRECT:
  - if_id_flush = id_ex_flush = 1; decrement the counter; return to RUN when it reaches 0.
  - A mem-wait condition takes priority: freeze, no flush, counter holds.
  - A new taken is ignored, since flushed instructions are invalid.
- LOAD_BUBBLE:
  - Exactly one cycle; outputs are 0 and the next state is RUN.
  - A mem-wait condition is honoured as in RUN case 1.
- Invariants:
  - pc_from_taken is never 1 while pc_stall = 1.
  - if_id_stall and if_id_flush are never both 1.
- stall_cnt increments on each cycle with pc_stall=1 and saturates at all-ones.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1, then a bubble cycle with outputs 0; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
2. Taken branch: ex_branch_taken=1, REDIRECT_CYCLES=1 -> one cycle of pc_from_taken=if_id_flush=id_ex_flush=1, pc_stall=0. With REDIRECT_CYCLES=3 -> flushes held 3 cycles, pc_from_taken only in the first.
3. Memory wait: mem_req=1, mem_ready low for 4 cycles then high -> pc_stall=ex_mem_stall=1 for exactly 4 cycles and 0 in the mem_ready cycle; stall_cnt=4.
4. Simultaneous events: mem-wait plus taken plus lu in the same cycle -> freeze only, no pc_from_taken. After mem_ready, with taken still asserted -> redirect in the next RUN cycle.
5. Timeout: MEM_TIMEOUT=8, mem_ready held 0 -> mem_timeout rises after the 8th wait cycle and stays 1 after mem_ready. Reset -> mem_timeout=0, stall_cnt=0.
6. Reset mid-REDIRECT (REDIRECT_CYCLES=4, reset in the 2nd cycle) -> all outputs 0 in the following cycle, state RUN.
